// File: rtl/ysyx_23060096_rf_wb_ctrl_if.sv
// ---------------------------------------------------------------------------
// ysyx_23060096_rf_wb_ctrl_if
// Bundle of every non-clock/reset signal of the register-file write-port
// controller.
//   req0_*   : EXU writeback request (valid/ready/addr/data)
//   req1_*   : LSU writeback request (valid/ready/addr/data)
//   sb_set_* : issue marks a destination register as pending
//   rs1/rs2  : read-port indices to check, with their busy flags
//   rd_busy  : sb_set_addr is already pending (WAW check)
//   rf_*     : registered register-file write port
//   init_done: zeroing sweep complete
//   dbg_state: FSM state (0 = INIT, 1 = RUN)
// master = writeback/issue side, slave = the controller.
//
// Handshake: a request transfers on a rising edge where valid && ready.
// ready is combinational and may depend on valid; a requester holds addr and
// data stable while valid && !ready and may not withdraw them before the
// transfer.
// ---------------------------------------------------------------------------
interface ysyx_23060096_rf_wb_ctrl_if #(
  parameter int ADDR_W = 5,
  parameter int DATA_W = 32
);
  logic              req0_valid;
  logic              req0_ready;
  logic [ADDR_W-1:0] req0_addr;
  logic [DATA_W-1:0] req0_data;
  logic              req1_valid;
  logic              req1_ready;
  logic [ADDR_W-1:0] req1_addr;
  logic [DATA_W-1:0] req1_data;
  logic              sb_set_valid;
  logic [ADDR_W-1:0] sb_set_addr;
  logic [ADDR_W-1:0] rs1_addr;
  logic [ADDR_W-1:0] rs2_addr;
  logic              rs1_busy;
  logic              rs2_busy;
  logic              rd_busy;
  logic              rf_wen;
  logic [ADDR_W-1:0] rf_waddr;
  logic [DATA_W-1:0] rf_wdata;
  logic              init_done;
  logic              dbg_state;

  modport master (
    output req0_valid, req0_addr, req0_data,
    output req1_valid, req1_addr, req1_data,
    output sb_set_valid, sb_set_addr, rs1_addr, rs2_addr,
    input  req0_ready, req1_ready, rs1_busy, rs2_busy, rd_busy,
    input  rf_wen, rf_waddr, rf_wdata, init_done, dbg_state
  );

  modport slave (
    input  req0_valid, req0_addr, req0_data,
    input  req1_valid, req1_addr, req1_data,
    input  sb_set_valid, sb_set_addr, rs1_addr, rs2_addr,
    output req0_ready, req1_ready, rs1_busy, rs2_busy, rd_busy,
    output rf_wen, rf_waddr, rf_wdata, init_done, dbg_state
  );
endinterface

// File: rtl/ysyx_23060096_rf_wb_ctrl.sv
// ---------------------------------------------------------------------------
// ysyx_23060096_rf_wb_ctrl
// Write-port controller and scoreboard for a 2^ADDR_W entry register file.
// After reset it writes zero to every register (INIT), then it arbitrates
// round-robin between the EXU (req0) and LSU (req1) writeback requests onto
// the single registered write port (RUN). A bit per register tracks
// in-flight destinations so issue can detect RAW/WAW hazards.
// Ports:
//   clk : rising-edge clock
//   rst : asynchronous active-high reset
//   bus : ysyx_23060096_rf_wb_ctrl_if.slave (requests, scoreboard, rf port)
// ---------------------------------------------------------------------------
module ysyx_23060096_rf_wb_ctrl #(
  parameter int ADDR_W = 5,
  parameter int DATA_W = 32
) (
  input logic                       clk,
  input logic                       rst,
  ysyx_23060096_rf_wb_ctrl_if.slave bus
);

  localparam int NREGS = 1 << ADDR_W;

  typedef enum logic {
    ST_INIT = 1'b0,
    ST_RUN  = 1'b1
  } state_t;

  state_t            state_q, state_d;
  logic [ADDR_W-1:0] cnt_q, cnt_d;
  logic              rr_q, rr_d;      // 0: req0 wins contention, 1: req1 wins
  logic [NREGS-1:0]  sb_q, sb_d;
  logic              rf_wen_q, rf_wen_d;
  logic [ADDR_W-1:0] rf_waddr_q, rf_waddr_d;
  logic [DATA_W-1:0] rf_wdata_q, rf_wdata_d;

  logic              run;
  logic              grant0, grant1;
  logic [ADDR_W-1:0] g_addr;
  logic [DATA_W-1:0] g_data;

  // State register and all datapath flops.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= ST_INIT;
      cnt_q      <= '0;
      rr_q       <= 1'b0;
      sb_q       <= '0;
      rf_wen_q   <= 1'b0;
      rf_waddr_q <= '0;
      rf_wdata_q <= '0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      rr_q       <= rr_d;
      sb_q       <= sb_d;
      rf_wen_q   <= rf_wen_d;
      rf_waddr_q <= rf_waddr_d;
      rf_wdata_q <= rf_wdata_d;
    end
  end

  // Next-state logic: INIT ends on the edge that writes the last index.
  always_comb begin
    state_d = state_q;
    if (state_q == ST_INIT && cnt_q == '1) begin
      state_d = ST_RUN;
    end
  end

  // Arbitration, scoreboard update and write-port next values.
  always_comb begin
    run    = (state_q == ST_RUN);
    grant0 = run && bus.req0_valid && (!bus.req1_valid || !rr_q);
    grant1 = run && bus.req1_valid && (!bus.req0_valid ||  rr_q);
    g_addr = grant1 ? bus.req1_addr : bus.req0_addr;
    g_data = grant1 ? bus.req1_data : bus.req0_data;

    cnt_d      = cnt_q;
    rr_d       = rr_q;
    sb_d       = sb_q;
    rf_wen_d   = 1'b0;
    rf_waddr_d = rf_waddr_q;
    rf_wdata_d = rf_wdata_q;

    if (!run) begin
      cnt_d      = cnt_q + ADDR_W'(1);
      rf_wen_d   = 1'b1;
      rf_waddr_d = cnt_q;
      rf_wdata_d = '0;
    end else begin
      // Pointer moves only when both sides competed for the port.
      if (bus.req0_valid && bus.req1_valid) begin
        rr_d = ~rr_q;
      end
      if (grant0 || grant1) begin
        // x0 writes are accepted but never reach the register file.
        rf_wen_d   = (g_addr != '0);
        rf_waddr_d = g_addr;
        rf_wdata_d = g_data;
        sb_d[g_addr] = 1'b0;
      end
      // Applied after the clear so a same-edge set to the same index wins.
      if (bus.sb_set_valid && bus.sb_set_addr != '0) begin
        sb_d[bus.sb_set_addr] = 1'b1;
      end
    end
  end

  // Outputs. Bit 0 of the scoreboard is never set, so index 0 reads idle.
  always_comb begin
    bus.req0_ready = grant0;
    bus.req1_ready = grant1;
    bus.rs1_busy   = run && sb_q[bus.rs1_addr];
    bus.rs2_busy   = run && sb_q[bus.rs2_addr];
    bus.rd_busy    = run && sb_q[bus.sb_set_addr];
    bus.rf_wen     = rf_wen_q;
    bus.rf_waddr   = rf_waddr_q;
    bus.rf_wdata   = rf_wdata_q;
    bus.init_done  = run;
    bus.dbg_state  = state_q;
  end

endmodule

// File: tb/tb_ysyx_23060096_rf_wb_ctrl.sv
// ---------------------------------------------------------------------------
// tb_ysyx_23060096_rf_wb_ctrl
// Directed bench: reset sweep, single write with scoreboard, round-robin
// contention, x0 / set-wins, and reset in the middle of RUN.
// Inputs change 1 time unit after a rising edge; outputs are checked there.
// ---------------------------------------------------------------------------
module tb_ysyx_23060096_rf_wb_ctrl;

  localparam int ADDR_W = 5;
  localparam int DATA_W = 32;

  logic clk;
  logic rst;
  int   n_tests;
  int   n_fail;

  ysyx_23060096_rf_wb_ctrl_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus ();

  ysyx_23060096_rf_wb_ctrl #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  // Clock / reset block.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Walks the 32-write zeroing sweep starting right after reset release.
  // req0 is held valid at x0 to show ready stays low until init_done.
  task automatic sweep_check(input string tag);
    for (int i = 0; i < (1 << ADDR_W); i++) begin
      tick();
      chk({tag, "_wen"},   32'(bus.rf_wen),   32'd1);
      chk({tag, "_waddr"}, 32'(bus.rf_waddr), 32'(i));
      chk({tag, "_wdata"}, bus.rf_wdata,      32'd0);
      chk({tag, "_done"},  32'(bus.init_done), (i == 31) ? 32'd1 : 32'd0);
      chk({tag, "_rdy0"},  32'(bus.req0_ready), (i == 31) ? 32'd1 : 32'd0);
      chk({tag, "_busy1"}, 32'(bus.rs1_busy), 32'd0);
    end
    bus.req0_valid   = 1'b0;
    bus.sb_set_valid = 1'b0;
    tick();
    chk({tag, "_wen_after"}, 32'(bus.rf_wen), 32'd0);
    #1;
    chk({tag, "_busy1_after"}, 32'(bus.rs1_busy), 32'd0);
  endtask

  initial begin
    n_tests = 0;
    n_fail  = 0;
    rst = 1'b1;
    bus.req0_valid   = 1'b1;
    bus.req0_addr    = '0;
    bus.req0_data    = '0;
    bus.req1_valid   = 1'b1;
    bus.req1_addr    = '0;
    bus.req1_data    = '0;
    bus.sb_set_valid = 1'b0;
    bus.sb_set_addr  = '0;
    bus.rs1_addr     = '0;
    bus.rs2_addr     = '0;

    // Reset state.
    #2;
    chk("rst_wen",   32'(bus.rf_wen),    32'd0);
    chk("rst_waddr", 32'(bus.rf_waddr),  32'd0);
    chk("rst_wdata", bus.rf_wdata,       32'd0);
    chk("rst_done",  32'(bus.init_done), 32'd0);
    chk("rst_rdy0",  32'(bus.req0_ready), 32'd0);
    chk("rst_rdy1",  32'(bus.req1_ready), 32'd0);
    chk("rst_state", 32'(bus.dbg_state), 32'd0);

    // Reset sweep; sb_set to 5 during INIT must be ignored.
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    bus.req1_valid   = 1'b0;
    bus.sb_set_valid = 1'b1;
    bus.sb_set_addr  = 5'd5;
    bus.rs1_addr     = 5'd5;
    sweep_check("sweep");
    chk("run_state", 32'(bus.dbg_state), 32'd1);

    // Single write through the scoreboard.
    bus.sb_set_valid = 1'b1;
    bus.sb_set_addr  = 5'd5;
    tick();
    bus.sb_set_valid = 1'b0;
    #1;
    chk("sw_busy_set", 32'(bus.rs1_busy), 32'd1);
    chk("sw_rd_busy",  32'(bus.rd_busy),  32'd1);
    bus.req0_valid = 1'b1;
    bus.req0_addr  = 5'd5;
    bus.req0_data  = 32'hDEADBEEF;
    #1;
    chk("sw_rdy0", 32'(bus.req0_ready), 32'd1);
    chk("sw_rdy1", 32'(bus.req1_ready), 32'd0);
    chk("sw_busy_hold", 32'(bus.rs1_busy), 32'd1);
    tick();
    bus.req0_valid = 1'b0;
    #1;
    chk("sw_wen",   32'(bus.rf_wen),   32'd1);
    chk("sw_waddr", 32'(bus.rf_waddr), 32'd5);
    chk("sw_wdata", bus.rf_wdata,      32'hDEADBEEF);
    chk("sw_busy_clr", 32'(bus.rs1_busy), 32'd0);

    // Contention, pointer fresh from reset (req0 favoured).
    bus.req0_valid = 1'b1; bus.req0_addr = 5'd3; bus.req0_data = 32'h11;
    bus.req1_valid = 1'b1; bus.req1_addr = 5'd4; bus.req1_data = 32'h22;
    #1;
    chk("c1_rdy0", 32'(bus.req0_ready), 32'd1);
    chk("c1_rdy1", 32'(bus.req1_ready), 32'd0);
    tick();
    bus.req0_addr = 5'd6; bus.req0_data = 32'h33;
    #1;
    chk("c1_wen",   32'(bus.rf_wen),   32'd1);
    chk("c1_waddr", 32'(bus.rf_waddr), 32'd3);
    chk("c1_wdata", bus.rf_wdata,      32'h11);
    chk("c2_rdy0",  32'(bus.req0_ready), 32'd0);
    chk("c2_rdy1",  32'(bus.req1_ready), 32'd1);
    tick();
    bus.req1_addr = 5'd8; bus.req1_data = 32'h44;
    #1;
    chk("c2_wen",   32'(bus.rf_wen),   32'd1);
    chk("c2_waddr", 32'(bus.rf_waddr), 32'd4);
    chk("c2_wdata", bus.rf_wdata,      32'h22);
    chk("c3_rdy0",  32'(bus.req0_ready), 32'd1);
    chk("c3_rdy1",  32'(bus.req1_ready), 32'd0);
    tick();
    bus.req0_valid = 1'b0;
    #1;
    chk("c3_waddr", 32'(bus.rf_waddr), 32'd6);
    chk("c3_wdata", bus.rf_wdata,      32'h33);
    chk("c4_rdy1",  32'(bus.req1_ready), 32'd1);
    tick();

    // x0 write: accepted, no rf write.
    bus.req1_addr = 5'd0; bus.req1_data = 32'hFF;
    #1;
    chk("c4_waddr", 32'(bus.rf_waddr), 32'd8);
    chk("c4_wdata", bus.rf_wdata,      32'h44);
    chk("x0_rdy1",  32'(bus.req1_ready), 32'd1);
    bus.rs1_addr = 5'd0;
    chk("x0_busy",  32'(bus.rs1_busy), 32'd0);
    tick();
    bus.req1_valid = 1'b0;
    #1;
    chk("x0_wen", 32'(bus.rf_wen), 32'd0);

    // Same-edge clear and set to 7: set wins.
    bus.req0_valid = 1'b1; bus.req0_addr = 5'd7; bus.req0_data = 32'h77;
    bus.sb_set_valid = 1'b1; bus.sb_set_addr = 5'd7;
    bus.rs2_addr = 5'd7;
    #1;
    chk("sw7_rdy0", 32'(bus.req0_ready), 32'd1);
    tick();
    bus.req0_valid = 1'b0;
    bus.sb_set_valid = 1'b0;
    #1;
    chk("sw7_wen",   32'(bus.rf_wen),   32'd1);
    chk("sw7_waddr", 32'(bus.rf_waddr), 32'd7);
    chk("sw7_busy2", 32'(bus.rs2_busy), 32'd1);

    // Reset mid-run: bit 9 busy, write to 10 in flight, req0 valid at 9.
    bus.sb_set_valid = 1'b1; bus.sb_set_addr = 5'd9;
    bus.req1_valid = 1'b1; bus.req1_addr = 5'd10; bus.req1_data = 32'hA;
    tick();
    bus.sb_set_valid = 1'b0;
    bus.req1_valid = 1'b0;
    bus.req0_valid = 1'b1; bus.req0_addr = 5'd9; bus.req0_data = 32'h99;
    bus.rs1_addr = 5'd9;
    #1;
    chk("mr_pre_wen",  32'(bus.rf_wen),     32'd1);
    chk("mr_pre_busy", 32'(bus.rs1_busy),   32'd1);
    chk("mr_pre_rdy0", 32'(bus.req0_ready), 32'd1);
    rst = 1'b1;
    #1;
    chk("mr_wen",   32'(bus.rf_wen),     32'd0);
    chk("mr_waddr", 32'(bus.rf_waddr),   32'd0);
    chk("mr_rdy0",  32'(bus.req0_ready), 32'd0);
    chk("mr_done",  32'(bus.init_done),  32'd0);
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    sweep_check("mr_sweep");

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/ysyx_23060096_rf_wb_ctrl.md
Name: ysyx_23060096_rf_wb_ctrl

Overview:
Write-port controller and scoreboard for the core register file (2^ADDR_W entries, single write port, two read ports).
- After reset, sweeps every register to zero.
- Then arbitrates round-robin between two writeback requesters (req0 = EXU, req1 = LSU) onto the single write port.
- Tracks in-flight destination registers so issue can detect RAW/WAW hazards.
- Sits between the writeback stage and the register file write port.

Parameters:
ADDR_W, 5, register index width; the file has 2^ADDR_W entries.
DATA_W, 32, register data width.

Ports:
clk  in  1  clock, rising edge.
rst  in  1  asynchronous reset, active-high.
init_done  out  1  high once the zeroing sweep is complete (state RUN).
req0_valid  in  1  EXU writeback request.
req0_ready  out  1  EXU request accepted this cycle.
req0_addr  in  ADDR_W  EXU destination register.
req0_data  in  DATA_W  EXU write data.
req1_valid  in  1  LSU writeback request.
req1_ready  out  1  LSU request accepted this cycle.
req1_addr  in  ADDR_W  LSU destination register.
req1_data  in  DATA_W  LSU write data.
sb_set_valid  in  1  issue marks a destination register as pending.
sb_set_addr  in  ADDR_W  register to mark.
rs1_addr  in  ADDR_W  read-port A index to check.
rs2_addr  in  ADDR_W  read-port B index to check.
rs1_busy  out  1  rs1_addr has a pending write.
rs2_busy  out  1  rs2_addr has a pending write.
rd_busy  out  1  sb_set_addr already pending (WAW check).
rf_wen  out  1  register file write enable (registered).
rf_waddr  out  ADDR_W  register file write address (registered).
rf_wdata  out  DATA_W  register file write data (registered).

Behaviour:
- Reset (async, rst=1): state=INIT, sweep counter=0, rr pointer=0 (req0 favoured), scoreboard all clear.
  - Outputs: rf_wen=0, rf_waddr=0, rf_wdata=0, init_done=0, req*_ready=0.
  - Assertion mid-operation aborts any sweep or in-flight write and restarts from INIT; pending requests are dropped.
- INIT state, one register per rising edge:
  - rf_wen<=1, rf_waddr<=cnt, rf_wdata<=0, cnt<=cnt+1.
  - The sweep includes index 0.
  - On the edge where cnt==2^ADDR_W-1, state<=RUN.
  - Resulting timing: rf_wen is high for exactly 2^ADDR_W cycles, and init_done rises together with the last sweep write on the outputs.
  - req*_ready=0 throughout INIT.
  - sb_set_valid is ignored in INIT; rs*_busy/rd_busy read 0.
- RUN state, arbitration (combinational ready):
  - Only req0_valid: req0_ready=1.
  - Only req1_valid: req1_ready=1.
  - Both valid: grant goes to the rr pointer side; the pointer flips to the other side on that edge.
  - Pointer changes only on a contended grant.
  - At most one ready is high per cycle.
  - A request is transferred when valid&&ready. A requester must hold addr/data stable while valid&&!ready.
- Write latency: the granted request appears on rf_wen/rf_waddr/rf_wdata on the next edge (1 cycle). rf_wen<=0 when there is no grant.
- Address 0:
  - A granted request with addr==0 is accepted (ready=1) but produces rf_wen=0.
  - Address 0 never becomes busy; rs*_busy for index 0 is always 0; sb_set to 0 is ignored.
- Scoreboard (2^ADDR_W bits, registered):
  - Set: sb_set_valid sets bit[sb_set_addr].
  - Clear: a transferred request clears bit[addr] on the same edge it is granted.
  - Same-edge set and clear to the same address: set wins (new producer outstanding).
  - sb_set_valid on an already busy address: the bit stays set. Issue must stall on rd_busy; this is a protocol violation and needs no extra handling.
  - Busy outputs are combinational reads of the registered bits. A clear is visible the cycle after the transfer; no same-cycle bypass.
- Writes to addresses not marked busy are legal and do not touch the scoreboard.

Test Plan:
- Reset sweep: assert rst for 3 cycles, release.
  - rf_wen=1 on 32 consecutive cycles with rf_waddr 0..31 and rf_wdata=0.
  - init_done rises with the final (addr 31) write; rf_wen=0 next cycle.
  - req0_ready stays 0 until init_done.
- Single write: after init, sb_set addr 5; rs1_addr=5 gives rs1_busy=1.
  - req0 addr 5, data 0xDEADBEEF: req0_ready=1.
  - Next cycle: rf_wen=1, rf_waddr=5, rf_wdata=0xDEADBEEF, rs1_busy=0.
- Contention: req0 (addr 3, 0x11) and req1 (addr 4, 0x22) both held valid from reset-fresh pointer.
  - Cycle 1: req0 granted.
  - Cycle 2: req1 granted.
  - rf writes 3/0x11 then 4/0x22 on consecutive cycles.
  - A third back-to-back pair is granted req0 first again.
- x0 and set-wins: req1 addr 0, data 0xFF: ready=1 but rf_wen stays 0.
  - Same edge: req0 granted to addr 7 and sb_set addr 7. Afterwards rs2_addr=7 gives rs2_busy=1.
- Reset mid-run: assert rst while req0 is valid at addr 9 with bit 9 busy.
  - Immediately: rf_wen=0, ready=0.
  - After release: a full 32-write sweep, and rs1_busy(9)=0 once RUN is entered.
